// File: rtl/dmem_responder_if.sv
// Load/store request and response bus between the MEM stage and the data-memory responder.
// The MEM stage drives the request side; the responder drives ready and the load response.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] addr;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        err;

   modport master (
      output req_valid, addr, wr, size, wdata,
      input  req_ready, rdata, rdata_valid, err
   );

   modport slave (
      input  req_valid, addr, wr, size, wdata,
      output req_ready, rdata, rdata_valid, err
   );
endinterface

// File: rtl/dmem_responder.sv
// Big-endian word-organised data RAM for the MEM stage: byte/half/word stores land in one cycle,
// loads return left-justified data READ_LATENCY cycles after acceptance.
module dmem_responder #(
   parameter int ADDR_WIDTH   = 10,
   parameter int READ_LATENCY = 2
) (
   input  logic             clk,
   input  logic             reset,
   dmem_responder_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

   stateT                  state, nextState;
   logic [3:0]             latCnt, nextLatCnt;
   logic [31:0]            mem [DEPTH];
   logic [31:0]            rdataQ;
   logic                   errQ;

   // Load request fields held while the read is in flight.
   logic [ADDR_WIDTH-1:0]  reqIdx;
   logic [1:0]             reqOff;
   logic [1:0]             reqSize;

   logic [ADDR_WIDTH-1:0]  wordIdx, capIdx;
   logic [1:0]             capOff, capSize;
   logic                   accept, reqErr, outOfRange, doStore, doLoad, capture;
   logic [3:0]             byteEn;
   logic [31:0]            laneData;

   // Move the addressed lane to the top of the word and clear everything below it.
   function automatic logic [31:0] formatLoad(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] sz);
      logic [31:0] shifted;
      shifted = word << {off, 3'b000};
      case (sz)
         2'b11:   return word;
         2'b01:   return {shifted[31:16], 16'h0000};
         default: return {shifted[31:24], 24'h000000};
      endcase
   endfunction

   assign wordIdx    = bus.addr[ADDR_WIDTH+1:2];
   assign outOfRange = (bus.addr >> (ADDR_WIDTH + 2)) != 32'd0;
   assign accept     = bus.req_valid && (state == IDLE) && !reset;
   assign doStore    = accept && !reqErr && bus.wr;
   assign doLoad     = accept && !reqErr && !bus.wr;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      reqErr = outOfRange;
      case (bus.size)
         2'b10:   reqErr = 1'b1;
         2'b01:   reqErr = reqErr || bus.addr[0];
         2'b11:   reqErr = reqErr || (bus.addr[1:0] != 2'b00);
         default: ;
      endcase
   end

   // Replicate store data onto every lane; byteEn picks which lanes actually change.
   always_comb begin
      byteEn   = 4'b1111;
      laneData = bus.wdata;
      case (bus.size)
         2'b00: begin
            byteEn   = 4'b1000 >> bus.addr[1:0];
            laneData = {4{bus.wdata[7:0]}};
         end
         2'b01: begin
            byteEn   = bus.addr[1] ? 4'b0011 : 4'b1100;
            laneData = {2{bus.wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      nextState  = state;
      nextLatCnt = latCnt;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (doLoad) begin
               if (READ_LATENCY == 1) begin
                  nextState = RESP;
                  capture   = 1'b1;
               end else begin
                  nextState  = WAIT;
                  nextLatCnt = 4'(READ_LATENCY - 1);
               end
            end
         end
         WAIT: begin
            nextLatCnt = latCnt - 4'd1;
            if (latCnt == 4'd1) begin
               nextState = RESP;
               capture   = 1'b1;
            end
         end
         RESP:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // With single-cycle latency the word is captured on the accepting edge, straight off the bus.
   assign capIdx  = (state == IDLE) ? wordIdx        : reqIdx;
   assign capOff  = (state == IDLE) ? bus.addr[1:0]  : reqOff;
   assign capSize = (state == IDLE) ? bus.size       : reqSize;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         latCnt <= 4'd0;
         rdataQ <= 32'd0;
         errQ   <= 1'b0;
      end else begin
         state  <= nextState;
         latCnt <= nextLatCnt;
         errQ   <= accept && reqErr;
         if (capture)
            rdataQ <= formatLoad(mem[capIdx], capOff, capSize);
      end
   end

   // NOTE: the RAM and the held request fields have no reset; memory contents survive a reset.
   always_ff @(posedge clk) begin
      if (doStore) begin
         for (int b = 0; b < 4; b++)
            if (byteEn[b])
               mem[wordIdx][b*8 +: 8] <= laneData[b*8 +: 8];
      end
      if (accept) begin
         reqIdx  <= wordIdx;
         reqOff  <= bus.addr[1:0];
         reqSize <= bus.size;
      end
   end

   assign bus.req_ready   = (state == IDLE);
   assign bus.rdata_valid = (state == RESP);
   assign bus.rdata       = rdataQ;
   assign bus.err         = errQ;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a latency-2 instance driven from a vector table and
// hand sequences, plus a latency-1 instance for the single-cycle load path.
module tb_dmem_responder;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   dmem_responder_if b2 ();
   dmem_responder_if b1 ();

   dmem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(LAT)) dut (.clk(clk), .reset(reset), .bus(b2));
   dmem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(1))   dut1 (.clk(clk), .reset(reset), .bus(b1));

   typedef struct {
      string       name;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        expErr;
      logic [31:0] expData;
   } vecT;

   vecT vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vecT mk(input string name, input logic wr, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic expErr, input logic [31:0] expData);
      vecT v;
      v.name = name; v.wr = wr; v.size = size; v.addr = addr;
      v.wdata = wdata; v.expErr = expErr; v.expData = expData;
      return v;
   endfunction

   task automatic drive2(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
      b2.req_valid = 1'b1; b2.wr = wr; b2.size = size; b2.addr = addr; b2.wdata = wdata;
   endtask

   // Entered and left at a negedge with the DUT idle.
   task automatic runVec(input vecT v);
      int   firstValid;
      int   validCnt;
      logic readyLow;
      logic sawErr;
      logic [31:0] data;
      check({v.name, ".ready_in"}, 32'(b2.req_ready), 32'd1);
      drive2(v.wr, v.size, v.addr, v.wdata);
      @(negedge clk);
      b2.req_valid = 1'b0;
      if (v.wr || v.expErr) begin
         check({v.name, ".err"},    32'(b2.err),         32'(v.expErr));
         check({v.name, ".valid0"}, 32'(b2.rdata_valid), 32'd0);
         check({v.name, ".ready0"}, 32'(b2.req_ready),   32'd1);
         @(negedge clk);
         check({v.name, ".err_end"}, 32'(b2.err),         32'd0);
         check({v.name, ".valid1"},  32'(b2.rdata_valid), 32'd0);
      end else begin
         firstValid = -1; validCnt = 0; readyLow = 1'b1; sawErr = 1'b0; data = 32'd0;
         for (int w = 0; w < 6; w++) begin
            if (b2.err) sawErr = 1'b1;
            if (firstValid < 0 || w == firstValid) readyLow = readyLow && !b2.req_ready;
            if (b2.rdata_valid) begin
               if (firstValid < 0) begin
                  firstValid = w;
                  data = b2.rdata;
                  readyLow = readyLow && !b2.req_ready;
               end
               validCnt++;
            end
            if (w < 5) @(negedge clk);
         end
         check({v.name, ".latency"},   32'(firstValid), 32'(LAT - 1));
         check({v.name, ".pulses"},    32'(validCnt),   32'd1);
         check({v.name, ".rdata"},     data,            v.expData);
         check({v.name, ".ready_low"}, 32'(readyLow),   32'd1);
         check({v.name, ".no_err"},    32'(sawErr),     32'd0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int sawValid;
      reset = 1'b1;
      b2.req_valid = 1'b0; b2.wr = 1'b0; b2.size = 2'b11; b2.addr = 32'd0; b2.wdata = 32'd0;
      b1.req_valid = 1'b0; b1.wr = 1'b0; b1.size = 2'b11; b1.addr = 32'd0; b1.wdata = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst.ready",  32'(b2.req_ready),   32'd1);
      check("rst.valid",  32'(b2.rdata_valid), 32'd0);
      check("rst.err",    32'(b2.err),         32'd0);
      check("rst.rdata",  b2.rdata,            32'd0);
      check("rst1.ready", 32'(b1.req_ready),   32'd1);

      // Byte stores on four consecutive edges, then a word load on the very next edge.
      for (int i = 0; i < 4; i++) begin
         drive2(1'b1, 2'b00, 32'h20 + 32'(i), 32'h11 * 32'(i + 1));
         @(negedge clk);
         check($sformatf("b2b.st%0d.ready", i), 32'(b2.req_ready), 32'd1);
         check($sformatf("b2b.st%0d.err", i),   32'(b2.err),       32'd0);
      end
      drive2(1'b0, 2'b11, 32'h20, 32'd0);
      @(negedge clk);
      b2.req_valid = 1'b0;
      check("raw.ready_w0", 32'(b2.req_ready),   32'd0);
      check("raw.valid_w0", 32'(b2.rdata_valid), 32'd0);
      @(negedge clk);
      check("raw.valid_w1", 32'(b2.rdata_valid), 32'd1);
      check("raw.rdata",    b2.rdata,            32'h11223344);
      check("raw.ready_w1", 32'(b2.req_ready),   32'd0);
      @(negedge clk);
      check("raw.valid_w2", 32'(b2.rdata_valid), 32'd0);
      check("raw.ready_w2", 32'(b2.req_ready),   32'd1);

      vecs.push_back(mk("st_w10",   1, 2'b11, 32'h10,   32'hDEADBEEF, 0, 32'h0));
      vecs.push_back(mk("ld_w10",   0, 2'b11, 32'h10,   32'h0,        0, 32'hDEADBEEF));
      vecs.push_back(mk("ld_b22",   0, 2'b00, 32'h22,   32'h0,        0, 32'h33000000));
      vecs.push_back(mk("ld_b21",   0, 2'b00, 32'h21,   32'h0,        0, 32'h22000000));
      vecs.push_back(mk("ld_h20",   0, 2'b01, 32'h20,   32'h0,        0, 32'h11220000));
      vecs.push_back(mk("st_w24",   1, 2'b11, 32'h24,   32'hFFFFFFFF, 0, 32'h0));
      vecs.push_back(mk("st_h26",   1, 2'b01, 32'h26,   32'h1234ABCD, 0, 32'h0));
      vecs.push_back(mk("ld_w24",   0, 2'b11, 32'h24,   32'h0,        0, 32'hFFFFABCD));
      vecs.push_back(mk("ld_h24",   0, 2'b01, 32'h24,   32'h0,        0, 32'hFFFF0000));
      vecs.push_back(mk("ld_h26",   0, 2'b01, 32'h26,   32'h0,        0, 32'hABCD0000));
      vecs.push_back(mk("ld_b27",   0, 2'b00, 32'h27,   32'h0,        0, 32'hCD000000));
      vecs.push_back(mk("st_w00",   1, 2'b11, 32'h00,   32'h01020304, 0, 32'h0));
      vecs.push_back(mk("st_w04",   1, 2'b11, 32'h04,   32'hCAFEF00D, 0, 32'h0));
      vecs.push_back(mk("st_wtop",  1, 2'b11, 32'hFFC,  32'h5A5AA5A5, 0, 32'h0));
      vecs.push_back(mk("e_ld_w02", 0, 2'b11, 32'h02,   32'h0,        1, 32'h0));
      vecs.push_back(mk("e_st_h05", 1, 2'b01, 32'h05,   32'h00009999, 1, 32'h0));
      vecs.push_back(mk("e_st_sz2", 1, 2'b10, 32'h20,   32'h0,        1, 32'h0));
      vecs.push_back(mk("e_ld_sz2", 0, 2'b10, 32'h10,   32'h0,        1, 32'h0));
      vecs.push_back(mk("e_st_oor", 1, 2'b11, 32'h1000, 32'hBAD0BAD0, 1, 32'h0));
      vecs.push_back(mk("e_ld_oor", 0, 2'b11, 32'h1000, 32'h0,        1, 32'h0));
      vecs.push_back(mk("ld_w00",   0, 2'b11, 32'h00,   32'h0,        0, 32'h01020304));
      vecs.push_back(mk("ld_w04",   0, 2'b11, 32'h04,   32'h0,        0, 32'hCAFEF00D));
      vecs.push_back(mk("ld_w20",   0, 2'b11, 32'h20,   32'h0,        0, 32'h11223344));
      vecs.push_back(mk("ld_wtop",  0, 2'b11, 32'hFFC,  32'h0,        0, 32'h5A5AA5A5));
      foreach (vecs[i]) runVec(vecs[i]);

      // Reset one cycle after a load is accepted: the load is dropped, RAM survives.
      drive2(1'b0, 2'b11, 32'h10, 32'd0);
      @(negedge clk);
      b2.req_valid = 1'b0;
      reset = 1'b1;
      sawValid = 0;
      @(negedge clk);
      reset = 1'b0;
      check("mid.ready", 32'(b2.req_ready), 32'd1);
      check("mid.rdata", b2.rdata,          32'd0);
      for (int w = 0; w < 5; w++) begin
         if (b2.rdata_valid) sawValid++;
         @(negedge clk);
      end
      check("mid.no_valid", 32'(sawValid), 32'd0);
      runVec(mk("mid.ld_w10", 0, 2'b11, 32'h10, 32'h0, 0, 32'hDEADBEEF));

      // Single-cycle latency: response one edge after acceptance, next load two edges after.
      b1.req_valid = 1'b1; b1.wr = 1'b1; b1.size = 2'b11; b1.addr = 32'h40; b1.wdata = 32'h12345678;
      @(negedge clk);
      b1.wr = 1'b0;
      @(negedge clk);
      check("l1.valid_n1", 32'(b1.rdata_valid), 32'd1);
      check("l1.rdata_w",  b1.rdata,            32'h12345678);
      check("l1.ready_n1", 32'(b1.req_ready),   32'd0);
      b1.size = 2'b00; b1.addr = 32'h41;
      @(negedge clk);
      check("l1.valid_n2", 32'(b1.rdata_valid), 32'd0);
      check("l1.ready_n2", 32'(b1.req_ready),   32'd1);
      @(negedge clk);
      b1.req_valid = 1'b0;
      check("l1.valid_n3", 32'(b1.rdata_valid), 32'd1);
      check("l1.rdata_b",  b1.rdata,            32'h34000000);
      @(negedge clk);
      check("l1.valid_n4", 32'(b1.rdata_valid), 32'd0);
      check("l1.ready_n4", 32'(b1.req_ready),   32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
